// File: rtl/gtfwizard_0_example_gtwiz_drp_arbiter.sv
// Two-master DRP arbiter in front of the GTF channel DRP port. Port 0 (align switch) has
// priority and can lock out port 1; a missing gt_drprdy_in is recovered by a timeout.
module gtfwizard_0_example_gtwiz_drp_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned FLUSH_CYCLES   = 16,
   parameter logic [15:0] TIMEOUT_DO     = 16'hFFFF
) (
   input  logic        freerun_clk_in,
   input  logic        freerun_rst_n_in,
   input  logic        s0_drpen_in,
   input  logic        s0_drpwe_in,
   input  logic [9:0]  s0_drpaddr_in,
   input  logic [15:0] s0_drpdi_in,
   input  logic        s0_lock_in,
   output logic        s0_drprdy_out,
   output logic [15:0] s0_drpdo_out,
   input  logic        s1_drpen_in,
   input  logic        s1_drpwe_in,
   input  logic [9:0]  s1_drpaddr_in,
   input  logic [15:0] s1_drpdi_in,
   output logic        s1_drprdy_out,
   output logic [15:0] s1_drpdo_out,
   output logic        gt_drpen_out,
   output logic        gt_drpwe_out,
   output logic [9:0]  gt_drpaddr_out,
   output logic [15:0] gt_drpdi_out,
   input  logic        gt_drprdy_in,
   input  logic [15:0] gt_drpdo_in,
   output logic        busy_out,
   output logic        timeout_out,
   output logic        proto_err_out
);
   localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t           state_r, state_nxt_s;
   logic             pend0_r, pend1_r, pend0_nxt_s, pend1_nxt_s;
   logic             cap0_we_r, cap1_we_r;
   logic [9:0]       cap0_addr_r, cap1_addr_r;
   logic [15:0]      cap0_di_r, cap1_di_r;
   logic             gnt1_r, gnt1_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             grant0_s, grant1_s, done_s, tmo_s, flush_end_s;
   logic             gt_en_nxt_s, gt_we_nxt_s;
   logic [9:0]       gt_addr_nxt_s;
   logic [15:0]      gt_di_nxt_s;
   logic             rsp0_s, rsp1_s, busy_nxt_s;
   logic [15:0]      rsp_do_s;
   logic             gt_en_r, gt_we_r, s0_rdy_r, s1_rdy_r, busy_r, timeout_r, proto_err_r;
   logic [9:0]       gt_addr_r;
   logic [15:0]      gt_di_r, s0_do_r, s1_do_r;

   // State register.
   always_ff @(posedge freerun_clk_in or negedge freerun_rst_n_in) begin
      if (!freerun_rst_n_in) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Grant, completion, timeout and flush-end decode for the current cycle.
   always_comb begin
      grant0_s    = 1'b0;
      grant1_s    = 1'b0;
      done_s      = 1'b0;
      tmo_s       = 1'b0;
      flush_end_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            grant0_s = pend0_r;
            grant1_s = !pend0_r && pend1_r && !s0_lock_in;
         end
         ST_WAIT: begin
            // A ready arriving on the last counted cycle still wins over the timeout.
            done_s = gt_drprdy_in;
            tmo_s  = !gt_drprdy_in && (cnt_r == TMO_LAST);
         end
         ST_FLUSH: begin
            flush_end_s = (cnt_r == FLUSH_LAST);
         end
         default: begin
            grant0_s = 1'b0;
         end
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant0_s || grant1_s) state_nxt_s = ST_WAIT;
            else                      state_nxt_s = ST_IDLE;
         end
         ST_WAIT: begin
            if (done_s)     state_nxt_s = ST_IDLE;
            else if (tmo_s) state_nxt_s = ST_FLUSH;
            else            state_nxt_s = ST_WAIT;
         end
         ST_FLUSH: begin
            if (flush_end_s) state_nxt_s = ST_IDLE;
            else             state_nxt_s = ST_FLUSH;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values; every output is registered from these.
   always_comb begin
      gt_en_nxt_s = grant0_s || grant1_s;
      if (grant0_s) begin
         gt_we_nxt_s   = cap0_we_r;
         gt_addr_nxt_s = cap0_addr_r;
         gt_di_nxt_s   = cap0_di_r;
      end else if (grant1_s) begin
         gt_we_nxt_s   = cap1_we_r;
         gt_addr_nxt_s = cap1_addr_r;
         gt_di_nxt_s   = cap1_di_r;
      end else begin
         gt_we_nxt_s   = 1'b0;
         gt_addr_nxt_s = 10'h000;
         gt_di_nxt_s   = 16'h0000;
      end

      if (gt_en_nxt_s || tmo_s || (state_r == ST_IDLE)) cnt_nxt_s = {CNT_W{1'b0}};
      else                                              cnt_nxt_s = cnt_r + CNT_W'(1);

      if (done_s) rsp_do_s = gt_drpdo_in;
      else        rsp_do_s = TIMEOUT_DO;
      rsp0_s = (done_s || tmo_s) && !gnt1_r;
      rsp1_s = (done_s || tmo_s) && gnt1_r;

      if (grant1_s)      gnt1_nxt_s = 1'b1;
      else if (grant0_s) gnt1_nxt_s = 1'b0;
      else               gnt1_nxt_s = gnt1_r;

      // A pending port cannot capture, so clear and set never coincide.
      if (pend0_r) pend0_nxt_s = !rsp0_s;
      else         pend0_nxt_s = s0_drpen_in;
      if (pend1_r) pend1_nxt_s = !rsp1_s;
      else         pend1_nxt_s = s1_drpen_in;

      busy_nxt_s = pend0_nxt_s || pend1_nxt_s || (state_nxt_s != ST_IDLE);
   end

   // Datapath and output registers.
   always_ff @(posedge freerun_clk_in or negedge freerun_rst_n_in) begin
      if (!freerun_rst_n_in) begin
         pend0_r     <= 1'b0;
         pend1_r     <= 1'b0;
         cap0_we_r   <= 1'b0;
         cap0_addr_r <= 10'h000;
         cap0_di_r   <= 16'h0000;
         cap1_we_r   <= 1'b0;
         cap1_addr_r <= 10'h000;
         cap1_di_r   <= 16'h0000;
         gnt1_r      <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
         gt_en_r     <= 1'b0;
         gt_we_r     <= 1'b0;
         gt_addr_r   <= 10'h000;
         gt_di_r     <= 16'h0000;
         s0_rdy_r    <= 1'b0;
         s1_rdy_r    <= 1'b0;
         s0_do_r     <= 16'h0000;
         s1_do_r     <= 16'h0000;
         busy_r      <= 1'b0;
         timeout_r   <= 1'b0;
         proto_err_r <= 1'b0;
      end else begin
         pend0_r <= pend0_nxt_s;
         pend1_r <= pend1_nxt_s;
         if (s0_drpen_in && !pend0_r) begin
            cap0_we_r   <= s0_drpwe_in;
            cap0_addr_r <= s0_drpaddr_in;
            cap0_di_r   <= s0_drpdi_in;
         end
         if (s1_drpen_in && !pend1_r) begin
            cap1_we_r   <= s1_drpwe_in;
            cap1_addr_r <= s1_drpaddr_in;
            cap1_di_r   <= s1_drpdi_in;
         end
         gnt1_r    <= gnt1_nxt_s;
         cnt_r     <= cnt_nxt_s;
         gt_en_r   <= gt_en_nxt_s;
         gt_we_r   <= gt_we_nxt_s;
         gt_addr_r <= gt_addr_nxt_s;
         gt_di_r   <= gt_di_nxt_s;
         s0_rdy_r  <= rsp0_s;
         s1_rdy_r  <= rsp1_s;
         if (rsp0_s) s0_do_r <= rsp_do_s;
         if (rsp1_s) s1_do_r <= rsp_do_s;
         busy_r      <= busy_nxt_s;
         timeout_r   <= timeout_r || tmo_s;
         proto_err_r <= proto_err_r || (s0_drpen_in && pend0_r) || (s1_drpen_in && pend1_r);
      end
   end

   assign gt_drpen_out   = gt_en_r;
   assign gt_drpwe_out   = gt_we_r;
   assign gt_drpaddr_out = gt_addr_r;
   assign gt_drpdi_out   = gt_di_r;
   assign s0_drprdy_out  = s0_rdy_r;
   assign s0_drpdo_out   = s0_do_r;
   assign s1_drprdy_out  = s1_rdy_r;
   assign s1_drpdo_out   = s1_do_r;
   assign busy_out       = busy_r;
   assign timeout_out    = timeout_r;
   assign proto_err_out  = proto_err_r;

endmodule

// File: tb/tb_gtfwizard_0_example_gtwiz_drp_arbiter.sv
// Bench for the two-master DRP arbiter: a GT register-file model answers strobes, and each
// scenario task predicts strobe/response cycles from the arbitration and latency rules.
module tb_gtfwizard_0_example_gtwiz_drp_arbiter;
   localparam int TMO   = 16;
   localparam int FLUSH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s0_drpen_in = 1'b0, s0_drpwe_in = 1'b0, s0_lock_in = 1'b0;
   logic [9:0]  s0_drpaddr_in = 10'h000;
   logic [15:0] s0_drpdi_in = 16'h0000;
   logic        s1_drpen_in = 1'b0, s1_drpwe_in = 1'b0;
   logic [9:0]  s1_drpaddr_in = 10'h000;
   logic [15:0] s1_drpdi_in = 16'h0000;
   logic        s0_drprdy_out, s1_drprdy_out;
   logic [15:0] s0_drpdo_out, s1_drpdo_out;
   logic        gt_drpen_out, gt_drpwe_out;
   logic [9:0]  gt_drpaddr_out;
   logic [15:0] gt_drpdi_out;
   logic        gt_drprdy_in = 1'b0;
   logic [15:0] gt_drpdo_in = 16'h0000;
   logic        busy_out, timeout_out, proto_err_out;

   gtfwizard_0_example_gtwiz_drp_arbiter #(
      .TIMEOUT_CYCLES(TMO), .FLUSH_CYCLES(FLUSH), .TIMEOUT_DO(16'hFFFF)
   ) dut (
      .freerun_clk_in(clk), .freerun_rst_n_in(rst_n),
      .s0_drpen_in(s0_drpen_in), .s0_drpwe_in(s0_drpwe_in), .s0_drpaddr_in(s0_drpaddr_in),
      .s0_drpdi_in(s0_drpdi_in), .s0_lock_in(s0_lock_in),
      .s0_drprdy_out(s0_drprdy_out), .s0_drpdo_out(s0_drpdo_out),
      .s1_drpen_in(s1_drpen_in), .s1_drpwe_in(s1_drpwe_in), .s1_drpaddr_in(s1_drpaddr_in),
      .s1_drpdi_in(s1_drpdi_in), .s1_drprdy_out(s1_drprdy_out), .s1_drpdo_out(s1_drpdo_out),
      .gt_drpen_out(gt_drpen_out), .gt_drpwe_out(gt_drpwe_out), .gt_drpaddr_out(gt_drpaddr_out),
      .gt_drpdi_out(gt_drpdi_out), .gt_drprdy_in(gt_drprdy_in), .gt_drpdo_in(gt_drpdo_in),
      .busy_out(busy_out), .timeout_out(timeout_out), .proto_err_out(proto_err_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   wire [64:0] all_outs = {gt_drpen_out, gt_drpwe_out, gt_drpaddr_out, gt_drpdi_out,
                           s0_drprdy_out, s0_drpdo_out, s1_drprdy_out, s1_drpdo_out,
                           busy_out, timeout_out, proto_err_out};

   typedef struct { int cyc; logic we; logic [9:0] addr; logic [15:0] di; } strobe_t;
   typedef struct { int cyc; logic [15:0] dout; } rsp_t;
   strobe_t     strobes[$];
   rsp_t        rsp0[$];
   rsp_t        rsp1[$];
   logic [15:0] gt_mem [int];
   int          bus_bad = 0;
   int          checks = 0;
   int          failures = 0;

   // GT model controls, written only by the stimulus process.
   bit gt_mute = 1'b0;
   int rdy_lat = 3;
   bit stray_req = 1'b0;
   int stray_at = 0;

   bit          rdy_pend = 1'b0;
   int          rdy_at = 0;
   logic [15:0] rdy_val = 16'h0000;

   // Unwritten GT registers read back a value derived from the address; RXSYNC_OVRD reads 16'h4000.
   function automatic logic [15:0] peek(input logic [9:0] a);
      if (gt_mem.exists(int'(a))) return gt_mem[int'(a)];
      else if (a == 10'h08A)     return 16'h4000;
      else                        return {a[5:0], a} ^ 16'h5A5A;
   endfunction

   always @(negedge clk) begin
      gt_drprdy_in = 1'b0;
      gt_drpdo_in  = 16'($urandom);
      if (rdy_pend && cyc == rdy_at) begin
         gt_drprdy_in = 1'b1;
         gt_drpdo_in  = rdy_val;
         rdy_pend     = 1'b0;
      end else if (stray_req && cyc == stray_at) begin
         gt_drprdy_in = 1'b1;
      end
      if (gt_drpen_out) begin
         strobes.push_back('{cyc, gt_drpwe_out, gt_drpaddr_out, gt_drpdi_out});
         if (!gt_mute) begin
            rdy_pend = 1'b1;
            rdy_at   = cyc + rdy_lat;
            rdy_val  = gt_drpwe_out ? 16'h0000 : peek(gt_drpaddr_out);
         end
         if (gt_drpwe_out) gt_mem[int'(gt_drpaddr_out)] = gt_drpdi_out;
      end else if (gt_drpwe_out || gt_drpaddr_out != 10'h000 || gt_drpdi_out != 16'h0000) begin
         bus_bad++;
      end
      if (s0_drprdy_out && s1_drprdy_out) bus_bad++;
      if (s0_drprdy_out) rsp0.push_back('{cyc, s0_drpdo_out});
      if (s1_drprdy_out) rsp1.push_back('{cyc, s1_drpdo_out});
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
      #1;
   endtask

   task automatic issue(input int port, input logic we, input logic [9:0] a, input logic [15:0] d,
                        output int rc);
      @(negedge clk);
      if (port == 0) begin
         s0_drpen_in = 1'b1; s0_drpwe_in = we; s0_drpaddr_in = a; s0_drpdi_in = d;
      end else begin
         s1_drpen_in = 1'b1; s1_drpwe_in = we; s1_drpaddr_in = a; s1_drpdi_in = d;
      end
      rc = cyc;
      @(negedge clk);
      s0_drpen_in = 1'b0; s0_drpwe_in = 1'($urandom); s0_drpaddr_in = 10'($urandom); s0_drpdi_in = 16'($urandom);
      s1_drpen_in = 1'b0; s1_drpwe_in = 1'($urandom); s1_drpaddr_in = 10'($urandom); s1_drpdi_in = 16'($urandom);
   endtask

   task automatic test_reset();
      settle(2);
      checks++;
      if (all_outs !== 65'd0) begin failures++; $display("FAIL reset_outs: got %h expected 0", all_outs); end
      s0_drpen_in = 1'b1;
      settle(1);
      s0_drpen_in = 1'b0;
      rst_n = 1'b1;
      settle(3);
      checks++;
      if (all_outs !== 65'd0) begin failures++; $display("FAIL post_reset_idle: got %h expected 0", all_outs); end
   endtask

   task automatic test_single_read();
      int r, sb, b0, b1;
      sb = strobes.size(); b0 = rsp0.size(); b1 = rsp1.size();
      rdy_lat = 3;
      issue(0, 1'b0, 10'h08A, 16'h1357, r);
      settle(12);
      checks++;
      if (strobes.size() != sb + 1) begin failures++; $display("FAIL rd_strobes: got %0d expected 1", strobes.size() - sb); end
      else begin
         checks++;
         if (strobes[sb].cyc != r + 2 || strobes[sb].addr !== 10'h08A || strobes[sb].we !== 1'b0) begin
            failures++;
            $display("FAIL rd_strobe: got cyc=%0d addr=%h we=%b expected cyc=%0d addr=08a we=0",
                     strobes[sb].cyc, strobes[sb].addr, strobes[sb].we, r + 2);
         end
      end
      checks++;
      if (rsp0.size() != b0 + 1) begin failures++; $display("FAIL rd_rsp0_count: got %0d expected 1", rsp0.size() - b0); end
      else begin
         checks++;
         if (rsp0[b0].cyc != r + 6 || rsp0[b0].dout !== 16'h4000) begin
            failures++;
            $display("FAIL rd_rsp0: got cyc=%0d do=%h expected cyc=%0d do=4000", rsp0[b0].cyc, rsp0[b0].dout, r + 6);
         end
      end
      checks++;
      if (rsp1.size() != b1) begin failures++; $display("FAIL rd_rsp1_quiet: got %0d expected 0", rsp1.size() - b1); end
   endtask

   task automatic test_random_single();
      for (int i = 0; i < 8; i++) begin
         int r, sb, b0, b1, port, lat, er, eo;
         logic we;
         logic [9:0] a;
         logic [15:0] d, e, got;
         port = int'($urandom_range(0, 1)); we = 1'($urandom); a = 10'($urandom); d = 16'($urandom);
         lat = int'($urandom_range(1, 6));
         rdy_lat = lat;
         e = we ? 16'h0000 : peek(a);
         sb = strobes.size(); b0 = rsp0.size(); b1 = rsp1.size();
         issue(port, we, a, d, r);
         settle(lat + 8);
         checks++;
         if (strobes.size() != sb + 1 || strobes[sb].cyc != r + 2 || strobes[sb].we !== we ||
             strobes[sb].addr !== a || strobes[sb].di !== d) begin
            failures++;
            $display("FAIL rand_strobe[%0d]: got n=%0d expected n=1 cyc=%0d we=%b addr=%h di=%h", i,
                     strobes.size() - sb, r + 2, we, a, d);
         end
         er = (port == 0) ? rsp0.size() - b0 : rsp1.size() - b1;
         eo = (port == 0) ? rsp1.size() - b1 : rsp0.size() - b0;
         checks++;
         if (er != 1 || eo != 0) begin
            failures++;
            $display("FAIL rand_rsp_count[%0d]: got own=%0d other=%0d expected 1/0", i, er, eo);
         end else begin
            got = (port == 0) ? rsp0[b0].dout : rsp1[b1].dout;
            checks++;
            if (((port == 0) ? rsp0[b0].cyc : rsp1[b1].cyc) != r + 3 + lat || got !== e) begin
               failures++;
               $display("FAIL rand_rsp[%0d]: got do=%h expected do=%h at cyc %0d", i, got, e, r + 3 + lat);
            end
         end
         checks++;
         if (busy_out !== 1'b0) begin failures++; $display("FAIL rand_busy_idle[%0d]: got %b expected 0", i, busy_out); end
      end
   endtask

   task automatic test_simultaneous();
      int r, sb, b0, b1, lat, r0;
      logic [15:0] e1;
      lat = int'($urandom_range(1, 5));
      rdy_lat = lat;
      e1 = peek(10'h100);
      sb = strobes.size(); b0 = rsp0.size(); b1 = rsp1.size();
      @(negedge clk);
      s0_drpen_in = 1'b1; s0_drpwe_in = 1'b1; s0_drpaddr_in = 10'h08A; s0_drpdi_in = 16'h0000;
      s1_drpen_in = 1'b1; s1_drpwe_in = 1'b0; s1_drpaddr_in = 10'h100; s1_drpdi_in = 16'hBEEF;
      r = cyc;
      @(negedge clk);
      s0_drpen_in = 1'b0; s1_drpen_in = 1'b0;
      settle(2 * lat + 10);
      r0 = r + 3 + lat;
      checks++;
      if (strobes.size() != sb + 2) begin failures++; $display("FAIL sim_strobes: got %0d expected 2", strobes.size() - sb); end
      else begin
         checks++;
         if (strobes[sb].cyc != r + 2 || strobes[sb].we !== 1'b1 || strobes[sb].addr !== 10'h08A || strobes[sb].di !== 16'h0000) begin
            failures++; $display("FAIL sim_s0_first: got cyc=%0d addr=%h expected cyc=%0d addr=08a", strobes[sb].cyc, strobes[sb].addr, r + 2);
         end
         checks++;
         if (strobes[sb+1].cyc != r0 + 1 || strobes[sb+1].we !== 1'b0 || strobes[sb+1].addr !== 10'h100) begin
            failures++; $display("FAIL sim_s1_second: got cyc=%0d addr=%h expected cyc=%0d addr=100", strobes[sb+1].cyc, strobes[sb+1].addr, r0 + 1);
         end
      end
      checks++;
      if (rsp0.size() != b0 + 1 || rsp1.size() != b1 + 1) begin
         failures++; $display("FAIL sim_rsp_count: got s0=%0d s1=%0d expected 1/1", rsp0.size() - b0, rsp1.size() - b1);
      end else begin
         checks++;
         if (rsp0[b0].cyc != r0 || rsp1[b1].cyc != r0 + 2 + lat || rsp1[b1].dout !== e1) begin
            failures++; $display("FAIL sim_rsp: got c0=%0d c1=%0d do1=%h expected c0=%0d c1=%0d do1=%h",
                                 rsp0[b0].cyc, rsp1[b1].cyc, rsp1[b1].dout, r0, r0 + 2 + lat, e1);
         end
      end
   endtask

   task automatic test_lock();
      int r1, r2, r3, d, sb, b0, b1, lat;
      logic [9:0] ar, aw, a1;
      logic [15:0] dw;
      lat = int'($urandom_range(1, 4));
      rdy_lat = lat;
      ar = 10'($urandom); aw = 10'($urandom); a1 = 10'($urandom); dw = 16'($urandom);
      sb = strobes.size(); b0 = rsp0.size(); b1 = rsp1.size();
      @(negedge clk);
      s0_lock_in = 1'b1;
      issue(0, 1'b0, ar, 16'h0000, r1);
      issue(1, 1'b0, a1, 16'h0000, r2);
      settle(lat + 6);
      issue(0, 1'b1, aw, dw, r3);
      settle(lat + 6);
      checks++;
      if (strobes.size() != sb + 2) begin failures++; $display("FAIL lock_blocks_s1: got %0d strobes expected 2", strobes.size() - sb); end
      @(negedge clk);
      s0_lock_in = 1'b0;
      d = cyc;
      settle(lat + 6);
      checks++;
      if (strobes.size() != sb + 3) begin failures++; $display("FAIL lock_strobes: got %0d expected 3", strobes.size() - sb); end
      else begin
         checks++;
         if (strobes[sb].addr !== ar || strobes[sb].cyc != r1 + 2 || strobes[sb+1].addr !== aw ||
             strobes[sb+1].we !== 1'b1 || strobes[sb+1].di !== dw || strobes[sb+2].addr !== a1) begin
            failures++; $display("FAIL lock_order: got %h,%h,%h expected %h,%h,%h",
                                 strobes[sb].addr, strobes[sb+1].addr, strobes[sb+2].addr, ar, aw, a1);
         end
         checks++;
         if (strobes[sb+2].cyc != d + 1) begin
            failures++; $display("FAIL lock_release: got cyc=%0d expected cyc=%0d", strobes[sb+2].cyc, d + 1);
         end
      end
      checks++;
      if (rsp0.size() != b0 + 2 || rsp1.size() != b1 + 1) begin
         failures++; $display("FAIL lock_rsp_count: got s0=%0d s1=%0d expected 2/1", rsp0.size() - b0, rsp1.size() - b1);
      end
   endtask

   task automatic test_timeout();
      int r, q, s, sb, b0, b1, lat;
      logic [9:0] a;
      logic [15:0] e;
      lat = int'($urandom_range(1, 4));
      a = 10'($urandom);
      sb = strobes.size(); b0 = rsp0.size(); b1 = rsp1.size();
      gt_mute = 1'b1;
      issue(1, 1'b0, 10'h155, 16'h0000, r);
      s = r + 2;
      stray_at = s + 16 + 5;
      stray_req = 1'b1;
      wait_until(s + 20);
      checks++;
      if (timeout_out !== 1'b1 || busy_out !== 1'b1) begin
         failures++; $display("FAIL tmo_flags: got timeout=%b busy=%b expected 1/1", timeout_out, busy_out);
      end
      wait_until(s + 25);
      gt_mute = 1'b0;
      rdy_lat = lat;
      e = peek(a);
      issue(0, 1'b0, a, 16'h0000, q);
      wait_until(s + 33 + lat + 5);
      stray_req = 1'b0;
      checks++;
      if (rsp1.size() != b1 + 1) begin failures++; $display("FAIL tmo_s1_count: got %0d expected 1", rsp1.size() - b1); end
      else begin
         checks++;
         if (rsp1[b1].cyc != s + TMO || rsp1[b1].dout !== 16'hFFFF) begin
            failures++; $display("FAIL tmo_rsp: got cyc=%0d do=%h expected cyc=%0d do=ffff", rsp1[b1].cyc, rsp1[b1].dout, s + TMO);
         end
      end
      checks++;
      if (strobes.size() != sb + 2 || strobes[sb].cyc != s || strobes[sb+1].cyc != s + 33 || strobes[sb+1].addr !== a) begin
         failures++; $display("FAIL tmo_after_flush_strobe: got n=%0d expected n=2, second at cyc=%0d", strobes.size() - sb, s + 33);
      end
      checks++;
      if (rsp0.size() != b0 + 1) begin failures++; $display("FAIL tmo_s0_count: got %0d expected 1", rsp0.size() - b0); end
      else begin
         checks++;
         if (rsp0[b0].cyc != s + 34 + lat || rsp0[b0].dout !== e) begin
            failures++; $display("FAIL tmo_s0_rsp: got cyc=%0d do=%h expected cyc=%0d do=%h", rsp0[b0].cyc, rsp0[b0].dout, s + 34 + lat, e);
         end
      end
   endtask

   task automatic test_proto_err();
      int r, rx, sb, b0, b1;
      logic [9:0] a;
      logic [15:0] e;
      checks++;
      if (proto_err_out !== 1'b0) begin failures++; $display("FAIL perr_initial: got %b expected 0", proto_err_out); end
      a = 10'($urandom);
      e = peek(a);
      rdy_lat = 6;
      sb = strobes.size(); b0 = rsp0.size(); b1 = rsp1.size();
      issue(1, 1'b0, a, 16'h0000, r);
      issue(1, 1'b1, 10'h3FF, 16'hDEAD, rx);
      issue(1, 1'b1, 10'h2AA, 16'hF00D, rx);
      settle(12);
      checks++;
      if (proto_err_out !== 1'b1) begin failures++; $display("FAIL perr_set: got %b expected 1", proto_err_out); end
      checks++;
      if (strobes.size() != sb + 1 || strobes[sb].addr !== a || strobes[sb].we !== 1'b0) begin
         failures++; $display("FAIL perr_strobes: got %0d expected 1 read of %h", strobes.size() - sb, a);
      end
      checks++;
      if (rsp1.size() != b1 + 1 || rsp0.size() != b0) begin
         failures++; $display("FAIL perr_rsp_count: got s1=%0d s0=%0d expected 1/0", rsp1.size() - b1, rsp0.size() - b0);
      end else begin
         checks++;
         if (rsp1[b1].cyc != r + 9 || rsp1[b1].dout !== e) begin
            failures++; $display("FAIL perr_rsp: got cyc=%0d do=%h expected cyc=%0d do=%h", rsp1[b1].cyc, rsp1[b1].dout, r + 9, e);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      int r, sb, b0, lat;
      logic [9:0] a;
      logic [15:0] e;
      checks++;
      if (timeout_out !== 1'b1 || proto_err_out !== 1'b1) begin
         failures++; $display("FAIL rst_pre_sticky: got timeout=%b perr=%b expected 1/1", timeout_out, proto_err_out);
      end
      gt_mute = 1'b1;
      issue(0, 1'b0, 10'h08A, 16'h0000, r);
      wait_until(r + 5);
      rst_n = 1'b0;
      #1;
      checks++;
      if (all_outs !== 65'd0) begin failures++; $display("FAIL rst_mid_wait: got %h expected 0", all_outs); end
      settle(2);
      checks++;
      if (all_outs !== 65'd0) begin failures++; $display("FAIL rst_held: got %h expected 0", all_outs); end
      rst_n = 1'b1;
      gt_mute = 1'b0;
      lat = int'($urandom_range(1, 5));
      rdy_lat = lat;
      a = 10'($urandom);
      e = peek(a);
      settle(2);
      sb = strobes.size(); b0 = rsp0.size();
      issue(0, 1'b0, a, 16'h0000, r);
      settle(lat + 8);
      checks++;
      if (strobes.size() != sb + 1 || strobes[sb].cyc != r + 2 || rsp0.size() != b0 + 1) begin
         failures++; $display("FAIL rst_recover_count: got strobes=%0d rsp=%0d expected 1/1", strobes.size() - sb, rsp0.size() - b0);
      end else begin
         checks++;
         if (rsp0[b0].cyc != r + 3 + lat || rsp0[b0].dout !== e) begin
            failures++; $display("FAIL rst_recover_rsp: got cyc=%0d do=%h expected cyc=%0d do=%h", rsp0[b0].cyc, rsp0[b0].dout, r + 3 + lat, e);
         end
      end
      checks++;
      if (bus_bad != 0) begin failures++; $display("FAIL bus_hygiene: got %0d violations expected 0", bus_bad); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_random_single();
      test_simultaneous();
      test_lock();
      test_timeout();
      test_proto_err();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gtfwizard_0_example_gtwiz_drp_arbiter.md
Name: gtfwizard_0_example_gtwiz_drp_arbiter

Overview:
- Two-master DRP arbiter sitting directly downstream of the RX buffer-bypass align switch; drives the single GTF channel DRP port.
- Port 0 is driven by the align switch's drpen/drpwe/drpaddr/drpdi outputs; its drprdy/drpdo are returned to that block. Port 1 is a general user/debug DRP master.
- Serialises transactions, honours a lock from the align switch so its read-modify-write of RXSYNC_OVRD (0x8A) is atomic, and recovers from a missing drprdy via timeout.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait for gt_drprdy_in before a synthetic response is issued; legal range >= 4.
- FLUSH_CYCLES, 16: cycles to discard stray gt_drprdy_in after a timeout; legal range >= 1.
- TIMEOUT_DO, 16'hFFFF: drpdo value returned on a timed-out transaction.

Ports:
- freerun_clk_in  in  1  free-running DRP clock; all logic is on its rising edge.
- freerun_rst_n_in  in  1  reset, asynchronous assert, active-low.
- s0_drpen_in  in  1  port 0 (align switch) request strobe, one cycle.
- s0_drpwe_in  in  1  port 0 write enable, qualified by s0_drpen_in.
- s0_drpaddr_in  in  10  port 0 address.
- s0_drpdi_in  in  16  port 0 write data.
- s0_lock_in  in  1  port 0 lock, driven by the align switch's drp_reconfig_rdy. While high, port 1 is not granted.
- s0_drprdy_out  out  1  port 0 completion pulse.
- s0_drpdo_out  out  16  port 0 read data, valid with s0_drprdy_out.
- s1_drpen_in, s1_drpwe_in, s1_drpaddr_in, s1_drpdi_in, s1_drprdy_out, s1_drpdo_out: same widths and meaning as port 0, for port 1.
- gt_drpen_out  out  1  DRP strobe to the GT.
- gt_drpwe_out  out  1  DRP write enable to the GT.
- gt_drpaddr_out  out  10  DRP address to the GT.
- gt_drpdi_out  out  16  DRP write data to the GT.
- gt_drprdy_in  in  1  GT DRP ready.
- gt_drpdo_in  in  16  GT DRP read data.
- busy_out  out  1  high while any transaction is pending or in flight.
- timeout_out  out  1  sticky; set on any timeout.
- proto_err_out  out  1  sticky; set on a request from a port that already has one pending.

Behaviour:
- Reset (freerun_rst_n_in low, asynchronous): all outputs 0, all drpdo outputs 16'h0000, pending flags cleared, counters 0, FSM in IDLE. Sticky flags clear only on reset.
- Capture:
  - sN_drpen_in high at an edge with pendN=0: latch we/addr/di into the port N capture register and set pendN.
  - If pendN=1 (in flight or waiting): drop the request and set proto_err_out.
- FSM states: IDLE, WAIT, FLUSH.
- IDLE grant rules:
  - Grant port 0 if pend0.
  - Otherwise grant port 1 if pend1 and s0_lock_in=0.
  - On grant: gt_drpen_out=1 for exactly one cycle with the latched we/addr/di; gt_drpwe_out is valid only in that cycle; clear the timeout counter; go to WAIT.
  - Simultaneous pend0 and pend1: port 0 wins; port 1 stays pending.
- Lock:
  - s0_lock_in blocks new port 1 grants only. A port 1 transaction already in WAIT completes normally.
  - Port 0 is never blocked.
- Request-to-strobe latency: request at edge E0 gives gt_drpen_out high in the cycle after E1, i.e. 2 cycles, when the port is granted immediately.
- WAIT:
  - gt_drpaddr_out and gt_drpdi_out return to 0 after the strobe cycle; the counter increments each cycle.
  - gt_drprdy_in=1: next cycle, the granted port's sN_drprdy_out=1 for one cycle and sN_drpdo_out=gt_drpdo_in (held until the next response). Clear its pend; go to IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 without rdy: respond to the granted port with drpdo=TIMEOUT_DO, set timeout_out, clear its pend, go to FLUSH.
  - rdy in the same cycle as the timeout: treat as a normal response, no timeout.
- FLUSH: ignore gt_drprdy_in for FLUSH_CYCLES cycles, then go to IDLE. Requests are still captured during FLUSH.
- gt_drprdy_in in IDLE or FLUSH: ignored, no response generated.
- Back-to-back: the earliest next gt_drpen_out is 1 cycle after the response cycle, because IDLE issues on the following edge.
- busy_out = pend0 | pend1 | (state != IDLE), registered.
- The ungranted port's drprdy_out is never asserted.

Test Plan:
- Port 0 read of 0x08A; GT returns rdy 3 cycles after strobe with do=16'h4000 -> gt_drpen_out with addr 0x08A, we=0, 2 cycles after request; s0_drprdy_out 1 cycle after rdy with s0_drpdo_out=16'h4000; s1_drprdy_out stays 0.
- s0 write to 0x08A (di=16'h0000) and s1 read of 0x100 in the same cycle -> s0 issued first, s1 issued 1 cycle after s0_drprdy_out; each port receives exactly one rdy.
- s0_lock_in held high across a s0 read, s1 request and s0 write; lock then dropped -> GT order is s0 read, s0 write, s1; s1 strobe only after lock low.
- GT never asserts rdy for an s1 request (TIMEOUT_CYCLES=16) -> s1_drprdy_out at strobe+16 with 16'hFFFF and timeout_out=1; a stray rdy 5 cycles later gives no response; the next s0 request completes normally after FLUSH.
- s1_drpen_in pulsed twice while its first request is in flight -> proto_err_out=1, exactly one GT transaction and one s1_drprdy_out.
- freerun_rst_n_in asserted low mid-WAIT -> all outputs 0 immediately, sticky flags cleared; after release a new s0 request completes with standard latency.
